// File: rtl/valid_ready_byte_packer.sv
// Packs BEAT_W-bit valid/ready beats little-endian into BEATS-beat words with keep/last.
// Optional macro VALID_READY_PACKER_BYPASS_EN: in_ready also follows out_ready for full throughput.
module valid_ready_byte_packer #(
  parameter int unsigned BEATS  = 4,
  parameter int unsigned BEAT_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BEAT_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BEATS*BEAT_W-1:0]   out_data,
  output logic [BEATS-1:0]          out_keep,
  output logic                      out_last
);

  localparam int unsigned WORD_W = BEATS * BEAT_W;
  localparam int unsigned CNT_W  = $clog2(BEATS);

  logic [WORD_W-1:0] acc_q, acc_d, acc_merged;
  logic [BEATS-1:0]  keep_q, keep_d, keep_merged;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] out_data_d;
  logic [BEATS-1:0]  out_keep_d;
  logic              out_last_d;
  logic              out_valid_d;
  logic              in_fire, out_fire, word_done;

  // Without the bypass the output register must be empty before a beat is taken.
`ifdef VALID_READY_PACKER_BYPASS_EN
  assign in_ready = !reset && (!out_valid || out_ready);
`else
  assign in_ready = !reset && !out_valid;
`endif

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign word_done = (cnt_q == CNT_W'(BEATS - 1)) || in_last;

  // Next-state: merge beat into accumulator, hand completed word to the output register.
  always_comb begin
    acc_d       = acc_q;
    keep_d      = keep_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data;
    out_keep_d  = out_keep;
    out_last_d  = out_last;
    out_valid_d = out_valid;

    acc_merged                                 = acc_q;
    acc_merged[32'(cnt_q) * BEAT_W +: BEAT_W]  = in_data;
    keep_merged                                = keep_q;
    keep_merged[cnt_q]                         = 1'b1;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (in_fire) begin
      if (word_done) begin
        out_data_d  = acc_merged;
        out_keep_d  = keep_merged;
        out_last_d  = in_last;
        out_valid_d = 1'b1;
        cnt_d       = '0;
        acc_d       = '0;
        keep_d      = '0;
      end else begin
        acc_d  = acc_merged;
        keep_d = keep_merged;
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  // State register; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      keep_q    <= '0;
      cnt_q     <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      keep_q    <= keep_d;
      cnt_q     <= cnt_d;
      out_data  <= out_data_d;
      out_keep  <= out_keep_d;
      out_last  <= out_last_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_valid_ready_byte_packer.sv
// Randomized/directed bench for valid_ready_byte_packer against a byte-queue reference model.
// Build with VALID_READY_PACKER_BYPASS_EN to check the bypass variant.
module tb_valid_ready_byte_packer;

  localparam int unsigned BEATS  = 4;
  localparam int unsigned BEAT_W = 8;
  localparam int unsigned WORD_W = BEATS * BEAT_W;

  typedef struct {
    logic [WORD_W-1:0] data;
    logic [BEATS-1:0]  keep;
    logic              last;
  } word_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [BEAT_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WORD_W-1:0] out_data;
  logic [BEATS-1:0]  out_keep;
  logic              out_last;

  valid_ready_byte_packer #(.BEATS(BEATS), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_words  = 0;

  logic [BEAT_W-1:0] part_q[$];
  word_t             exp_q[$];
  logic [BEAT_W-1:0] in_bytes[$];
  logic [BEAT_W-1:0] out_bytes[$];
  word_t             last_w;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, evaluate both handshakes just before the next posedge.
  task automatic step(input logic rst, input logic v, input logic [BEAT_W-1:0] d,
                      input logic l, input logic ordy, output logic fired);
    logic  exp_rdy;
    word_t w;
    @(negedge clk);
    reset = rst; in_valid = v; in_data = d; in_last = l; out_ready = ordy;
    #1;
    fired = 1'b0;
    if (rst) begin
      check_eq("in_ready_in_reset", 64'(in_ready), 64'd0);
      part_q.delete();
      exp_q.delete();
    end else begin
`ifdef VALID_READY_PACKER_BYPASS_EN
      exp_rdy = (exp_q.size() == 0) || ordy;
`else
      exp_rdy = (exp_q.size() == 0);
`endif
      check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
      check_eq("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        check_eq("out_data", 64'(out_data), 64'(exp_q[0].data));
        check_eq("out_keep", 64'(out_keep), 64'(exp_q[0].keep));
        check_eq("out_last", 64'(out_last), 64'(exp_q[0].last));
        if (ordy) begin
          last_w = exp_q.pop_front();
          n_words++;
          for (int i = 0; i < int'(BEATS); i++)
            if (out_keep[i]) out_bytes.push_back(out_data[i*BEAT_W +: BEAT_W]);
        end
      end
      if (v && in_ready) begin
        fired = 1'b1;
        in_bytes.push_back(d);
        part_q.push_back(d);
        if (part_q.size() == BEATS || l) begin
          w.data = '0;
          w.keep = '0;
          for (int i = 0; i < part_q.size(); i++) begin
            w.data[i*BEAT_W +: BEAT_W] = part_q[i];
            w.keep[i] = 1'b1;
          end
          w.last = l;
          exp_q.push_back(w);
          part_q.delete();
        end
      end
    end
  endtask

  task automatic send_beat(input logic [BEAT_W-1:0] d, input logic l, input logic ordy);
    logic f = 1'b0;
    for (int n = 0; n < 50 && !f; n++) step(1'b0, 1'b1, d, l, ordy, f);
    check_eq("send_timeout", 64'(f), 64'd1);
  endtask

  task automatic drain();
    logic f;
    for (int n = 0; n < 100 && (exp_q.size() != 0 || out_valid); n++)
      step(1'b0, 1'b0, '0, 1'b0, 1'b1, f);
    check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_keep", 64'(out_keep), 64'd0);
    check_eq("rst_out_last", 64'(out_last), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic f;
    logic [BEAT_W-1:0] rnd[50];
    int unsigned idx, fires, words0;
    logic hold;

    // Reset state
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, f);
    step(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, f);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, f);
    check_reset_outputs();

    // Full word
    send_beat(8'h11, 1'b0, 1'b1); send_beat(8'h22, 1'b0, 1'b1);
    send_beat(8'h33, 1'b0, 1'b1); send_beat(8'h44, 1'b0, 1'b1);
    drain();
    check_eq("w_full_data", 64'(last_w.data), 64'h44332211);
    check_eq("w_full_keep", 64'(last_w.keep), 64'hF);
    check_eq("w_full_last", 64'(last_w.last), 64'd0);

    // Partial word closed by in_last, then single-beat word from slot 0
    send_beat(8'hAA, 1'b0, 1'b1); send_beat(8'hBB, 1'b0, 1'b1); send_beat(8'hCC, 1'b1, 1'b1);
    drain();
    check_eq("w_part_data", 64'(last_w.data), 64'h00CCBBAA);
    check_eq("w_part_keep", 64'(last_w.keep), 64'h7);
    check_eq("w_part_last", 64'(last_w.last), 64'd1);
    send_beat(8'hDD, 1'b1, 1'b1);
    drain();
    check_eq("w_one_data", 64'(last_w.data), 64'h000000DD);
    check_eq("w_one_keep", 64'(last_w.keep), 64'h1);

    // in_last on the final slot
    send_beat(8'h55, 1'b0, 1'b1); send_beat(8'h66, 1'b0, 1'b1);
    send_beat(8'h77, 1'b0, 1'b1); send_beat(8'h88, 1'b1, 1'b1);
    drain();
    check_eq("w_fl_data", 64'(last_w.data), 64'h88776655);
    check_eq("w_fl_keep", 64'(last_w.keep), 64'hF);
    check_eq("w_fl_last", 64'(last_w.last), 64'd1);

    // Backpressure: word held while in_valid stays high
    send_beat(8'hA1, 1'b0, 1'b0); send_beat(8'hA2, 1'b0, 1'b0);
    send_beat(8'hA3, 1'b0, 1'b0); send_beat(8'hA4, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) begin
      step(1'b0, 1'b1, 8'h99, 1'b0, 1'b0, f);
      check_eq("stall_no_accept", 64'(f), 64'd0);
    end
    send_beat(8'h99, 1'b1, 1'b1);
    drain();
    check_eq("w_after_stall", 64'(last_w.data), 64'h00000099);

    // Random traffic: 50 bytes, in_last on the last one
    in_bytes.delete(); out_bytes.delete();
    words0 = n_words;
    foreach (rnd[i]) rnd[i] = BEAT_W'($urandom);
    idx = 0; hold = 1'b0;
    for (int n = 0; n < 2000 && idx < 50; n++) begin
      logic v;
      v = hold ? 1'b1 : 1'($urandom_range(1));
      step(1'b0, v, rnd[idx], idx == 49, 1'($urandom_range(1)), f);
      if (f) begin idx++; hold = 1'b0; end
      else hold = v;
    end
    check_eq("rand_all_sent", 64'(idx), 64'd50);
    drain();
    check_eq("rand_word_cnt", 64'(n_words - words0), 64'd13);
    check_eq("rand_byte_cnt", 64'(out_bytes.size()), 64'd50);
    for (int i = 0; i < 50 && i < out_bytes.size(); i++)
      check_eq("rand_byte", 64'(out_bytes[i]), 64'(rnd[i]));

    // Reset in the middle of a word
    send_beat(8'hE1, 1'b0, 1'b1); send_beat(8'hE2, 1'b0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, f);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, f);
    check_reset_outputs();
    send_beat(8'h01, 1'b0, 1'b1); send_beat(8'h02, 1'b0, 1'b1);
    send_beat(8'h03, 1'b0, 1'b1); send_beat(8'h04, 1'b0, 1'b1);
    drain();
    check_eq("w_post_rst_data", 64'(last_w.data), 64'h04030201);
    check_eq("w_post_rst_keep", 64'(last_w.keep), 64'hF);

    // Sustained throughput with out_ready tied high
    fires = 0;
    for (int n = 0; n < 20; n++) begin
      step(1'b0, 1'b1, BEAT_W'($urandom), 1'b0, 1'b1, f);
      if (f) fires++;
    end
`ifdef VALID_READY_PACKER_BYPASS_EN
    check_eq("throughput", 64'(fires), 64'd20);
`else
    check_eq("throughput", 64'(fires), 64'd16);
`endif
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
